axi3_write_slave_mem: RTL
=========================

Name: axi3_write_slave_mem

Overview:
Parametrised AXI3 write-channel slave with an integrated word-addressed memory array. It is the successor to the fixed 32-bit WriteSlave + Memory pair. It accepts AW/W/B handshakes from a WriteMaster, performs FIXED, INCR and WRAP bursts with byte strobes and narrow transfers, detects protocol and address errors, and returns BID/BRESP. A combinational backdoor read port lets benches and read logic inspect memory contents.

Parameters:
DATA_W, 32, data bus width in bits; legal values 32, 64, 128.
ADDR_W, 32, AWADDR width.
ID_W, 4, AWID/WID/BID width.
DEPTH, 128, memory depth in DATA_W-bit words; power of two.
BASE_ADDR, 0, byte address of word 0; must be aligned to DEPTH*DATA_W/8.

Ports:
ACLK  in  1  clock; all logic on the rising edge.
ARESETn  in  1  asynchronous active-low reset.
AWID  in  ID_W  write address ID.
AWADDR  in  ADDR_W  start byte address.
AWLEN  in  4  beats minus 1.
AWSIZE  in  3  log2 of bytes per beat.
AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
AWLOCK  in  2  accepted, ignored.
AWCACHE  in  4  accepted, ignored.
AWPROT  in  3  accepted, ignored.
AWVALID  in  1  address valid.
AWREADY  out  1  address ready.
WID  in  ID_W  write data ID.
WDATA  in  DATA_W  write data.
WSTRB  in  DATA_W/8  byte strobes.
WLAST  in  1  last beat.
WVALID  in  1  data valid.
WREADY  out  1  data ready.
BID  out  ID_W  response ID.
BRESP  out  2  00 OKAY, 10 SLVERR.
BVALID  out  1  response valid.
BREADY  in  1  response ready.
dbg_addr  in  clog2(DEPTH)  backdoor word index.
dbg_data  out  DATA_W  memory word at dbg_addr; combinational.
wr_done  out  1  one-cycle pulse on B handshake.

Behaviour:
- Clock and reset: single clock ACLK. Reset ARESETn is asynchronous and active-low. On reset: state goes to IDLE; AWREADY=0, WREADY=0, BVALID=0, BID=0, BRESP=00, wr_done=0. Memory array is not reset.
- The slave holds one outstanding transaction at a time.
- FSM IDLE:
  - AWREADY=1.
  - On AWVALID&AWREADY, latch AWID, AWADDR, AWLEN, AWSIZE, AWBURST; clear beat counter and error flag; go to DATA.
- FSM DATA:
  - AWREADY=0, WREADY=1 starting the cycle after the AW handshake.
  - Each WVALID&WREADY beat writes the bytes of the current word whose WSTRB bit is 1, in the same edge.
  - Beat is dropped and error set if: WID≠latched AWID; address outside [BASE_ADDR, BASE_ADDR+DEPTH*DATA_W/8); or the transaction is illegal.
  - Illegal transaction: 2^AWSIZE > DATA_W/8; AWBURST=11; or a WRAP violation (see below). An illegal transaction writes no beats.
  - Exit to RESP on the beat that has WLAST=1 or beat count = AWLEN, whichever comes first. If the two do not coincide, set error.
- FSM RESP:
  - BVALID=1, BID=latched AWID, BRESP=SLVERR if error else OKAY.
  - Hold all three until BREADY. On the handshake, pulse wr_done and return to IDLE.
  - AWREADY stays 0 until IDLE; the earliest next AW is the cycle after the B handshake.
- Address update per beat:
  - FIXED: address unchanged.
  - INCR: next = aligned(addr, size) + 2^AWSIZE.
  - WRAP: boundary = (AWLEN+1)<<AWSIZE; the address wraps within that aligned window.
  - Word index = (addr-BASE_ADDR) >> log2(DATA_W/8).
  - Lane placement is the master's responsibility; the slave applies WSTRB as given.
- Legal WRAP: AWLEN ∈ {1,3,7,15} and AWADDR aligned to 2^AWSIZE. Anything else is a WRAP violation and makes the transaction illegal.
- Latency: AW handshake at cycle n; WREADY from n+1; a burst of L+1 beats with no stalls ends at n+L+1; BVALID at n+L+2.
- Backdoor read: dbg_data reflects a write on the following cycle; there is no same-cycle bypass.

Optional Feature:
- Macro: AXI3_WSLV_WID_CHECK_EN.
- When defined: WID mismatch drops the beat and forces SLVERR, as described above.
- When undefined: WID is ignored and never causes an error; all other checks are unchanged.

Decomposition:
- Package axi3_pkg holds:
  - burst encodings BURST_FIXED/INCR/WRAP;
  - response codes RESP_OKAY/EXOKAY/SLVERR/DECERR;
  - the FSM state enum wslv_state_t (IDLE, DATA, RESP).
- Sub-module axi3_burst_addr_gen: combinational next-address and WRAP-legality calculation from addr, len, size, burst. It is reused later by the read slave.

Test Plan:
- Base configuration for all scenarios: DATA_W=32, BASE_ADDR=0, AWID=4'h5, WID matching.
- INCR: AWADDR=0x08, AWLEN=3, AWSIZE=2, WDATA=1,2,3,4, WSTRB=F → words 2..5 = 1..4; BRESP=00; BID=5; wr_done pulses once.
- Strobes: word 0 preloaded with 0xAABBCCDD; single beat 0x11223344, WSTRB=4'b0011 → word 0 = 0xAABB3344.
- WRAP: AWADDR=0x18, AWLEN=3, AWSIZE=2, data A,B,C,D → words 6,7,4,5 = A,B,C,D; OKAY.
- Out of range: AWADDR=0x200 (DEPTH*4), one beat → memory unchanged; BRESP=10.
- Early WLAST: AWLEN=3, WLAST asserted on beat 2 → two words written; SLVERR; FSM returns to IDLE.
- Back-pressure and reset:
  - BREADY low for 5 cycles → BVALID/BID/BRESP stable and AWREADY=0 throughout.
  - ARESETn low mid-burst → outputs 0 asynchronously and state returns to IDLE.

Source files
------------

// File: rtl/axi3_pkg.sv
// ----------------------------------------------------------------------------
// axi3_pkg
// Shared AXI3 encodings used by the write slave and its address generator:
//   - burst type encodings (BURST_FIXED / BURST_INCR / BURST_WRAP)
//   - response codes (RESP_OKAY / RESP_EXOKAY / RESP_SLVERR / RESP_DECERR)
//   - write-slave FSM state enum wslv_state_t (IDLE, DATA, RESP)
// ----------------------------------------------------------------------------
package axi3_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } wslv_state_t;

endpackage

// File: rtl/axi3_burst_addr_gen.sv
// ----------------------------------------------------------------------------
// axi3_burst_addr_gen
// Combinational AXI3 burst address step and WRAP legality check. Shared by the
// write slave and the read slave.
// Ports:
//   addr_i      current beat byte address
//   len_i       AxLEN (beats minus 1)
//   size_i      AxSIZE (log2 bytes per beat)
//   burst_i     AxBURST
//   next_addr_o byte address of the following beat
//   wrap_ok_o   1 when addr_i/len_i/size_i form a legal WRAP start
// ----------------------------------------------------------------------------
module axi3_burst_addr_gen
    import axi3_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [3:0]        len_i,
    input  logic [2:0]        size_i,
    input  logic [1:0]        burst_i,
    output logic [ADDR_W-1:0] next_addr_o,
    output logic              wrap_ok_o
);

    logic [ADDR_W-1:0] size_mask;
    logic [ADDR_W-1:0] aligned;
    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] wrap_mask;

    always_comb begin
        size_mask = (ADDR_W'(1) << size_i) - ADDR_W'(1);
        aligned   = addr_i & ~size_mask;
        incr      = aligned + (ADDR_W'(1) << size_i);
        // Wrap window is (len+1) beats wide; for legal lengths it is a power of
        // two, so the window base is kept and only the low bits advance.
        wrap_mask = ((ADDR_W'(len_i) + ADDR_W'(1)) << size_i) - ADDR_W'(1);

        next_addr_o = addr_i;
        case (burst_i)
            BURST_INCR: next_addr_o = incr;
            BURST_WRAP: next_addr_o = (addr_i & ~wrap_mask) | (incr & wrap_mask);
            default:    next_addr_o = addr_i;
        endcase

        wrap_ok_o = (len_i inside {4'd1, 4'd3, 4'd7, 4'd15}) &&
                    ((addr_i & size_mask) == '0);
    end

endmodule

// File: rtl/axi3_write_slave_mem.sv
// ----------------------------------------------------------------------------
// axi3_write_slave_mem
// AXI3 write-channel slave with an integrated word-addressed memory. One
// outstanding transaction; FIXED/INCR/WRAP bursts, byte strobes, narrow beats.
//
// Handshakes: a transfer happens on a rising edge where VALID and READY are
// both 1. READY/VALID outputs are registered and depend only on FSM state.
//
// Ports:
//   ACLK, ARESETn              clock, asynchronous active-low reset
//   AW* (AWREADY out)          write address channel
//   W*  (WREADY out)           write data channel
//   BID, BRESP, BVALID, BREADY write response channel
//   dbg_addr / dbg_data        combinational backdoor read of one memory word
//   dbg_state                  current FSM state (wslv_state_t encoding)
//   wr_done                    high during the B handshake cycle
//
// Optional feature macro: AXI3_WSLV_WID_CHECK_EN
//   defined   -> a beat whose WID differs from the latched AWID is dropped and
//                the response becomes SLVERR
//   undefined -> WID is ignored
// ----------------------------------------------------------------------------
module axi3_write_slave_mem
    import axi3_pkg::*;
#(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       ID_W      = 4,
    parameter int unsigned       DEPTH     = 128,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic [ID_W-1:0]          AWID,
    input  logic [ADDR_W-1:0]        AWADDR,
    input  logic [3:0]               AWLEN,
    input  logic [2:0]               AWSIZE,
    input  logic [1:0]               AWBURST,
    input  logic [1:0]               AWLOCK,
    input  logic [3:0]               AWCACHE,
    input  logic [2:0]               AWPROT,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [ID_W-1:0]          WID,
    input  logic [DATA_W-1:0]        WDATA,
    input  logic [DATA_W/8-1:0]      WSTRB,
    input  logic                     WLAST,
    input  logic                     WVALID,
    output logic                     WREADY,
    output logic [ID_W-1:0]          BID,
    output logic [1:0]               BRESP,
    output logic                     BVALID,
    input  logic                     BREADY,
    input  logic [$clog2(DEPTH)-1:0] dbg_addr,
    output logic [DATA_W-1:0]        dbg_data,
    output logic [1:0]               dbg_state,
    output logic                     wr_done
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int HI     = OFF_W + IDX_W;

    wslv_state_t       state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        len_q, len_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        burst_q, burst_d;
    logic [3:0]        beat_q, beat_d;
    logic              err_q, err_d;
    logic              illegal_q, illegal_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [ID_W-1:0]   bid_q, bid_d;
    logic [1:0]        bresp_q, bresp_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              aw_hs, w_hs, b_hs;
    logic              id_ok, in_range, beat_ok, last_beat, len_match, aw_illegal;
    logic [IDX_W-1:0]  widx;
    logic [ADDR_W-1:0] gen_addr, next_addr;
    logic [3:0]        gen_len;
    logic [2:0]        gen_size;
    logic [1:0]        gen_burst;
    logic              wrap_ok;
    logic              unused_sideband;

`ifdef AXI3_WSLV_WID_CHECK_EN
    assign id_ok           = (WID == id_q);
    assign unused_sideband = ^{AWLOCK, AWCACHE, AWPROT};
`else
    assign id_ok           = 1'b1;
    assign unused_sideband = ^{AWLOCK, AWCACHE, AWPROT, WID};
`endif

    // In IDLE the generator looks at the incoming AW so WRAP legality is known
    // at the handshake; afterwards it steps the latched beat address.
    assign gen_addr  = (state_q == IDLE) ? AWADDR  : addr_q;
    assign gen_len   = (state_q == IDLE) ? AWLEN   : len_q;
    assign gen_size  = (state_q == IDLE) ? AWSIZE  : size_q;
    assign gen_burst = (state_q == IDLE) ? AWBURST : burst_q;

    axi3_burst_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .addr_i      (gen_addr),
        .len_i       (gen_len),
        .size_i      (gen_size),
        .burst_i     (gen_burst),
        .next_addr_o (next_addr),
        .wrap_ok_o   (wrap_ok)
    );

    assign aw_hs = AWVALID & awready_q;
    assign w_hs  = WVALID & wready_q;
    assign b_hs  = bvalid_q & BREADY;

    assign aw_illegal = (AWSIZE > 3'(OFF_W)) || (AWBURST == 2'b11) ||
                        ((AWBURST == BURST_WRAP) && !wrap_ok);

    // BASE_ADDR is aligned to the array span, so the range test is a compare of
    // the bits above the array and the word index needs no subtraction.
    assign in_range  = (addr_q[ADDR_W-1:HI] == BASE_ADDR[ADDR_W-1:HI]);
    assign widx      = addr_q[HI-1:OFF_W];
    assign beat_ok   = !illegal_q && in_range && id_ok;
    assign len_match = (beat_q == len_q);
    assign last_beat = WLAST || len_match;

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        beat_d    = beat_q;
        err_d     = err_q;
        illegal_d = illegal_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;

        case (state_q)
            IDLE: begin
                if (aw_hs) begin
                    id_d      = AWID;
                    addr_d    = AWADDR;
                    len_d     = AWLEN;
                    size_d    = AWSIZE;
                    burst_d   = AWBURST;
                    beat_d    = 4'd0;
                    err_d     = 1'b0;
                    illegal_d = aw_illegal;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (w_hs) begin
                    addr_d = next_addr;
                    beat_d = beat_q + 4'd1;
                    // A mismatch between WLAST and the AWLEN count is an error.
                    if (!beat_ok || (last_beat && (WLAST != len_match))) begin
                        err_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = RESP;
                        bid_d   = id_q;
                        bresp_d = err_d ? RESP_SLVERR : RESP_OKAY;
                    end
                end
            end
            RESP: begin
                if (b_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        awready_d = (state_d == IDLE);
        wready_d  = (state_d == DATA);
        bvalid_d  = (state_d == RESP);
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= IDLE;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            beat_q    <= '0;
            err_q     <= 1'b0;
            illegal_q <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            beat_q    <= beat_d;
            err_q     <= err_d;
            illegal_q <= illegal_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
        end
    end

    // Memory contents are not reset.
    always_ff @(posedge ACLK) begin
        if (w_hs && beat_ok) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (WSTRB[b]) begin
                    mem_q[widx][b*8 +: 8] <= WDATA[b*8 +: 8];
                end
            end
        end
    end

    assign AWREADY   = awready_q;
    assign WREADY    = wready_q;
    assign BVALID    = bvalid_q;
    assign BID       = bid_q;
    assign BRESP     = bresp_q;
    assign wr_done   = b_hs;
    assign dbg_data  = mem_q[dbg_addr];
    assign dbg_state = state_q;

endmodule
